// File: rtl/lsu_pkg.sv
// Shared types, IO address map and lane/extension helpers for the lsu_mmio_v2 load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IO,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] IO_LEDR = 32'h7000;
    localparam logic [31:0] IO_LEDG = 32'h7010;
    localparam logic [31:0] IO_HEX  = 32'h7020;
    localparam logic [31:0] IO_LCD  = 32'h7030;
    localparam logic [31:0] IO_SW   = 32'h7800;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Anything that is not a byte or half access behaves as a word access.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (is_byte(f3)) return 1'b0;
        if (is_half(f3)) return off[0];
        return off != 2'b00;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        if (is_byte(f3)) return 4'b0001 << off;
        if (is_half(f3)) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] d);
        if (is_byte(f3)) return {4{d[7:0]}};
        if (is_half(f3)) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0]        lane;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        lane = word >> {off, 3'b000};
        b    = lane[7:0];
        h    = lane[15:0];
        case (f3)
            F3_B:    r = 32'(b);
            F3_BU:   r = {24'h0, lane[7:0]};
            F3_H:    r = 32'(h);
            F3_HU:   r = {16'h0, lane[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/lsu_io_regs.sv
// Peripheral register file: byte-masked writes, read mux, and a 2-flop switch synchronizer.
module lsu_io_regs
    import lsu_pkg::*;
#(
    parameter int N_HEX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [31:0]        word_addr,
    input  logic [3:0]         bmask,
    input  logic [31:0]        wdata,
    input  logic [31:0]        sw,
    output logic [31:0]        rdata,
    output logic [31:0]        ledr,
    output logic [31:0]        ledg,
    output logic [31:0]        lcd,
    output logic [8*N_HEX-1:0] hex
);

    localparam int N_HW = N_HEX / 4;

    logic [31:0] hex_q [N_HW];
    logic [31:0] sw_meta;
    logic [31:0] sw_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr    <= '0;
            ledg    <= '0;
            lcd     <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
            for (int j = 0; j < N_HW; j++) hex_q[j] <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (we) begin
                if (word_addr == IO_LEDR) ledr <= merge_bytes(ledr, wdata, bmask);
                if (word_addr == IO_LEDG) ledg <= merge_bytes(ledg, wdata, bmask);
                if (word_addr == IO_LCD)  lcd  <= merge_bytes(lcd, wdata, bmask);
                // Segment digits have no decimal point: bit 7 of every byte stays clear.
                for (int j = 0; j < N_HW; j++)
                    if (word_addr == IO_HEX + 32'(4 * j))
                        hex_q[j] <= merge_bytes(hex_q[j], wdata, bmask) & 32'h7F7F_7F7F;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (word_addr == IO_LEDR) rdata = ledr;
        if (word_addr == IO_LEDG) rdata = ledg;
        if (word_addr == IO_LCD)  rdata = lcd;
        if (word_addr == IO_SW)   rdata = sw_sync;
        for (int j = 0; j < N_HW; j++)
            if (word_addr == IO_HEX + 32'(4 * j)) rdata = hex_q[j];
    end

    always_comb begin
        hex = '0;
        for (int j = 0; j < N_HW; j++) hex[32*j +: 32] = hex_q[j];
    end

endmodule

// File: rtl/lsu_mmio_v2.sv
// Load/store unit top: request handshake FSM, SRAM request/ack port and IO register access.
module lsu_mmio_v2
    import lsu_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE = 32'h2000,
    parameter logic [31:0] SRAM_LAST = 32'h3FFF,
    parameter int          N_HEX     = 8,
    parameter int          TIMEOUT   = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_wren,
    input  logic [2:0]         i_req_funct3,
    input  logic [31:0]        i_req_addr,
    input  logic [31:0]        i_req_wdata,
    output logic               o_rsp_valid,
    output logic [31:0]        o_rsp_rdata,
    output logic               o_rsp_err,
    output logic [17:0]        o_mem_addr,
    output logic [31:0]        o_mem_wdata,
    output logic [3:0]         o_mem_bmask,
    output logic               o_mem_wren,
    output logic               o_mem_rden,
    input  logic [31:0]        i_mem_rdata,
    input  logic               i_mem_ack,
    input  logic [31:0]        i_io_sw,
    output logic [31:0]        o_io_ledr,
    output logic [31:0]        o_io_ledg,
    output logic [31:0]        o_io_lcd,
    output logic [8*N_HEX-1:0] o_io_hex
);

    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             wren_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       bmask_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      io_rdata;
    logic             in_sram;

    assign in_sram = (i_req_addr >= SRAM_BASE) && (i_req_addr <= SRAM_LAST);

    lsu_io_regs #(.N_HEX(N_HEX)) u_io (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .we        ((state == ST_IO) && wren_q),
        .word_addr ({addr_q[31:2], 2'b00}),
        .bmask     (bmask_q),
        .wdata     (wdata_q),
        .sw        (i_io_sw),
        .rdata     (io_rdata),
        .ledr      (o_io_ledr),
        .ledg      (o_io_ledg),
        .lcd       (o_io_lcd),
        .hex       (o_io_hex)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
            o_mem_wren  <= 1'b0;
            o_mem_rden  <= 1'b0;
            wren_q      <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bmask_q     <= '0;
            cnt         <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            o_mem_wren  <= 1'b0;
            o_mem_rden  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        o_req_ready <= 1'b0;
                        wren_q      <= i_req_wren;
                        f3_q        <= i_req_funct3;
                        addr_q      <= i_req_addr;
                        wdata_q     <= store_rep(i_req_funct3, i_req_wdata);
                        bmask_q     <= lane_mask(i_req_funct3, i_req_addr[1:0]);
                        if (misaligned(i_req_funct3, i_req_addr[1:0])) begin
                            state       <= ST_RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b1;
                        end else if (in_sram) begin
                            state       <= ST_MEM_REQ;
                            o_mem_addr  <= {i_req_addr[17:2], 2'b00};
                            o_mem_wdata <= store_rep(i_req_funct3, i_req_wdata);
                            o_mem_bmask <= lane_mask(i_req_funct3, i_req_addr[1:0]);
                            o_mem_wren  <= i_req_wren;
                            o_mem_rden  <= !i_req_wren;
                        end else begin
                            state <= ST_IO;
                        end
                    end
                end
                ST_IO: begin
                    state       <= ST_RESP;
                    o_rsp_valid <= 1'b1;
                    o_rsp_rdata <= wren_q ? 32'h0 : load_ext(io_rdata, f3_q, addr_q[1:0]);
                end
                // cnt tracks cycles since the strobe; an ack in the strobe cycle is ignored.
                ST_MEM_REQ: begin
                    state <= ST_MEM_WAIT;
                    cnt   <= CNT_W'(1);
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ack) begin
                        state       <= ST_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= wren_q ? 32'h0 : load_ext(i_mem_rdata, f3_q, addr_q[1:0]);
                    end else if (cnt == CNT_LAST) begin
                        state       <= ST_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    o_req_ready <= 1'b1;
                    o_rsp_rdata <= '0;
                    o_rsp_err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mmio_v2.sv
// Directed bench for lsu_mmio_v2: IO map, lane handling, SRAM handshake, misalignment, timeout, reset.
module tb_lsu_mmio_v2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid, i_req_wren;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr, i_req_wdata;
    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic [17:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren, o_mem_rden;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic [31:0] i_io_sw;
    logic [31:0] o_io_ledr, o_io_ledg, o_io_lcd;
    logic [63:0] o_io_hex;

    int errors = 0;
    int checks = 0;

    lsu_mmio_v2 dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wren(i_req_wren),
        .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .o_mem_wren(o_mem_wren), .o_mem_rden(o_mem_rden),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack), .i_io_sw(i_io_sw),
        .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg), .o_io_lcd(o_io_lcd), .o_io_hex(o_io_hex)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present a request in an IDLE cycle; returns one cycle after the accept edge.
    task automatic issue(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        i_req_valid  = 1'b1;
        i_req_wren   = wren;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        step();
        i_req_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic saw;
        i_rst = 1'b0; i_req_valid = 1'b0; i_req_wren = 1'b0; i_req_funct3 = 3'b000;
        i_req_addr = '0; i_req_wdata = '0; i_mem_rdata = '0; i_mem_ack = 1'b0;
        i_io_sw = 32'h0;
        step(); step();
        i_rst = 1'b1;
        step();
        check("rst_ready", o_req_ready, 1);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rdata", o_rsp_rdata, 0);
        check("rst_rden", o_mem_rden, 0);
        check("rst_ledr", o_io_ledr, 0);
        check("rst_hex", o_io_hex, 0);

        // Store W to LEDR
        issue(1'b1, 3'b010, 32'h7000, 32'h1234_5678);
        check("io_c1_valid", o_rsp_valid, 0);
        check("io_c1_ready", o_req_ready, 0);
        step();
        check("io_c2_valid", o_rsp_valid, 1);
        check("io_c2_err", o_rsp_err, 0);
        check("io_c2_rdata", o_rsp_rdata, 0);
        check("ledr", o_io_ledr, 32'h1234_5678);
        step();
        check("io_c3_ready", o_req_ready, 1);
        check("io_c3_valid", o_rsp_valid, 0);

        // Byte store then loads on LEDG lane 1
        issue(1'b1, 3'b000, 32'h7011, 32'h0000_00AB);
        step();
        check("ledg", o_io_ledg, 32'h0000_AB00);
        step();
        issue(1'b0, 3'b100, 32'h7011, 32'h0);
        step();
        check("lbu_valid", o_rsp_valid, 1);
        check("lbu_rdata", o_rsp_rdata, 32'h0000_00AB);
        step();
        issue(1'b0, 3'b000, 32'h7011, 32'h0);
        step();
        check("lb_rdata", o_rsp_rdata, 32'hFFFF_FFAB);
        step();

        // Half load from SRAM; ack in strobe cycle must be ignored
        issue(1'b0, 3'b001, 32'h2002, 32'h0);
        check("lh_rden", o_mem_rden, 1);
        check("lh_wren", o_mem_wren, 0);
        check("lh_bmask", o_mem_bmask, 4'b1100);
        check("lh_addr", o_mem_addr, 18'h2000);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        step();
        i_mem_ack = 1'b0;
        check("lh_rden_pulse", o_mem_rden, 0);
        check("lh_early_ack", o_rsp_valid, 0);
        check("lh_wait_ready", o_req_ready, 0);
        step(); step();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h8001_0000;
        step();
        i_mem_ack = 1'b0;
        check("lh_valid", o_rsp_valid, 1);
        check("lh_rdata", o_rsp_rdata, 32'hFFFF_8001);
        check("lh_err", o_rsp_err, 0);
        check("lh_addr_hold", o_mem_addr, 18'h2000);
        step();

        // Half store to SRAM, ack in first wait cycle
        issue(1'b1, 3'b001, 32'h2002, 32'h0000_BEEF);
        check("sh_wren", o_mem_wren, 1);
        check("sh_rden", o_mem_rden, 0);
        check("sh_wdata", o_mem_wdata, 32'hBEEF_BEEF);
        check("sh_bmask", o_mem_bmask, 4'b1100);
        step();
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        check("sh_valid", o_rsp_valid, 1);
        check("sh_rdata", o_rsp_rdata, 0);
        step();

        // Misaligned word store
        issue(1'b1, 3'b010, 32'h2001, 32'hFFFF_FFFF);
        check("mis_valid", o_rsp_valid, 1);
        check("mis_err", o_rsp_err, 1);
        check("mis_wren", o_mem_wren, 0);
        check("mis_rdata", o_rsp_rdata, 0);
        step();
        check("mis_ready", o_req_ready, 1);
        check("mis_ledr_kept", o_io_ledr, 32'h1234_5678);

        // HEX word 1 with forced-clear bit 7, LCD half, SW read, unmapped read
        issue(1'b1, 3'b010, 32'h7024, 32'hFFFF_FFFF);
        step();
        check("hex1", o_io_hex, 64'h7F7F_7F7F_0000_0000);
        step();
        issue(1'b1, 3'b001, 32'h7032, 32'h0000_1234);
        step();
        check("lcd", o_io_lcd, 32'h1234_0000);
        step();
        i_io_sw = 32'hCAFE_F00D;
        step(); step(); step();
        issue(1'b0, 3'b010, 32'h7800, 32'h0);
        step();
        check("sw_rdata", o_rsp_rdata, 32'hCAFE_F00D);
        step();
        issue(1'b0, 3'b010, 32'h7100, 32'h0);
        step();
        check("unmap_valid", o_rsp_valid, 1);
        check("unmap_rdata", o_rsp_rdata, 0);
        check("unmap_err", o_rsp_err, 0);
        step();

        // Timeout: no ack ever
        issue(1'b0, 3'b010, 32'h2000, 32'h0);
        check("to_rden", o_mem_rden, 1);
        n = 0;
        while (!o_rsp_valid && n < 400) begin
            step();
            n++;
        end
        check("to_latency", n, 255);
        check("to_err", o_rsp_err, 1);
        check("to_rdata", o_rsp_rdata, 0);
        step();

        // Reset during MEM_WAIT
        issue(1'b0, 3'b010, 32'h2004, 32'h0);
        step();
        check("rm_wait_ready", o_req_ready, 0);
        i_rst = 1'b0;
        #1;
        check("rm_ledr_clr", o_io_ledr, 0);
        check("rm_rden", o_mem_rden, 0);
        step(); step();
        i_rst = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (o_rsp_valid) saw = 1'b1;
        end
        check("rm_no_rsp", saw, 0);
        check("rm_ready", o_req_ready, 1);
        check("rm_ledg", o_io_ledg, 0);
        check("rm_lcd", o_io_lcd, 0);
        check("rm_hex", o_io_hex, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mmio_v2.md
# lsu_mmio_v2

Second-generation load/store unit for the pipelined core: accepts one load or store per handshake, decodes the address into an SRAM window or memory-mapped I/O registers, and supports byte/half/word accesses with sign extension and byte-lane masks. It sits between the MEM stage and the external SRAM controller. The controller attaches through a generic request/ack memory port rather than raw SRAM pins. Misaligned accesses and memory timeouts are reported as errors.

## Interface
Parameters:
- SRAM_BASE, 32'h2000, first SRAM byte address.
- SRAM_LAST, 32'h3FFF, last SRAM byte address (inclusive).
- N_HEX, 8, number of 7-segment digits; multiple of 4.
- TIMEOUT, 255, max cycles waiting for i_mem_ack; width $clog2(TIMEOUT+1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  unit can accept a request.
- i_req_wren  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- o_rsp_err  out  1  misaligned or timeout.
- o_mem_addr  out  18  word-aligned SRAM offset (i_req_addr[17:0] with [1:0]=0).
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_bmask  out  4  byte lanes.
- o_mem_wren, o_mem_rden  out  1  one-cycle strobes.
- i_mem_rdata  in  32  read data, valid with ack.
- i_mem_ack  in  1  completion.
- i_io_sw  in  32  switches (asynchronous).
- o_io_ledr, o_io_ledg, o_io_lcd  out  32  peripheral registers.
- o_io_hex  out  8*N_HEX  digit byte k at [8k+7:8k]; bit 7 of each byte forced 0.

## Operation
- States: IDLE, IO, MEM_REQ, MEM_WAIT, RESP. Reset → IDLE.
- IDLE: o_req_ready=1. On valid, latch request.
  - Misaligned (H with addr[0]=1, W with addr[1:0]≠0) → RESP, err=1, no side effect.
  - Address within [SRAM_BASE, SRAM_LAST] → MEM_REQ.
  - Otherwise → IO.
- IO map (word addresses):
  - 7000 LEDR; 7010 LEDG; 7020+4j HEX word j (j < N_HEX/4); 7030 LCD; 7800 SW (read-only).
  - Stores merge only masked bytes into the register.
  - Unmapped addresses: reads return 0, writes ignored, err=0.
  - → RESP.
- MEM_REQ: assert o_mem_wren or o_mem_rden for exactly one cycle → MEM_WAIT.
- MEM_WAIT:
  - On i_mem_ack → RESP with data from i_mem_rdata.
  - If the counter reaches TIMEOUT first → RESP, err=1, data 0.
- RESP: o_rsp_valid=1 for one cycle → IDLE.
- Lane mask: B = 1<<addr[1:0]; H = 0011 or 1100; W = 1111.
- Store data replicated: B {4{d[7:0]}}, H {2{d[15:0]}}.
- Loads: select lane by addr[1:0], then sign- or zero-extend per funct3.
- Undefined funct3 values are treated as W.
- i_io_sw passes through a 2-flop synchronizer; SW reads return the synchronized value.

## Timing
- Reset values: all outputs 0, except o_req_ready=1 after reset deasserts. State is IDLE.
- IO access: accept at cycle 0, o_rsp_valid at cycle 2.
- Misaligned access: o_rsp_valid at cycle 1.
- SRAM access: strobe at cycle 1; o_rsp_valid one cycle after the ack cycle.
- An ack in the same cycle as the strobe is not sampled; only acks in MEM_WAIT count.
- Ack and timeout in the same cycle: ack wins, err=0.
- o_req_ready=0 in every state except IDLE. No back-to-back accept; the next accept is no earlier than the cycle after RESP.
- o_mem_* address/data/mask are held stable from MEM_REQ until RESP.
- Reset mid-transaction: immediately IDLE, strobes drop, peripheral registers clear, no response is issued.

## Structure
- Package lsu_pkg:
  - state enum.
  - funct3 constants.
  - IO address localparams.
  - function for lane mask.
  - function for load extension.
- Sub-module lsu_io_regs: peripheral register file with byte-masked write, read mux and SW synchronizer. The top-level FSM owns the handshake and the memory port.

## Test plan
- Reset, then store W 32'h1234_5678 to 7000 → o_io_ledr=32'h1234_5678; rsp at cycle 2, err=0.
- Store B 8'hAB to 7011, then load BU from 7011 → o_io_ledg=32'h0000_AB00; load returns 32'h0000_00AB. Load B from 7011 returns 32'hFFFF_FFAB.
- Load H from 2002, memory model returns 32'h8001_0000 with ack after 3 cycles:
  - o_mem_rden one pulse with bmask 1100 and addr 18'h2000.
  - o_rsp_rdata=32'hFFFF_8001.
- Store W to 2001 → o_rsp_err=1 at cycle 1; no o_mem_wren; registers unchanged.
- Read 2000 with a memory model that never acks → err=1, rdata 0, exactly TIMEOUT cycles after the strobe.
- Pull i_rst low during MEM_WAIT → no o_rsp_valid, o_req_ready=1 after release, all IO outputs 0.
